// File: rtl/mem_game_pkg.sv
// Shared definitions for the memory card game: board geometry, value width
// and the turn-sequencer state encoding.
package mem_game_pkg;

   localparam int NUM_CARDS = 36;
   localparam int VAL_W     = 5;
   localparam int POS_W     = 6;
   localparam int PAIRS     = NUM_CARDS / 2;

   // Encodings are visible on inputState, so they are fixed explicitly.
   typedef enum logic [2:0] {
      PICK1   = 3'd0,
      READ1   = 3'd1,
      PICK2   = 3'd2,
      READ2   = 3'd3,
      COMPARE = 3'd4,
      SHOW    = 3'd5,
      DONE    = 3'd6
   } state_e;

endpackage

// File: rtl/memory_turn_ctrl_press_edge.sv
// Rising-edge detector for the select button. A level that is already high
// while reset is asserted must fall and rise again before it counts as a press.
module press_edge (
   input  logic clock_i,
   input  logic reset_i,
   input  logic a_i,
   output logic press_o
);

   logic a_prev_q;
   logic armed_q;

   // armed_q blocks the first edge after reset when A was held high through
   // reset, so that level is not taken as a second press.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         a_prev_q <= 1'b0;
         armed_q  <= ~a_i;
      end else begin
         a_prev_q <= a_i;
         armed_q  <= armed_q | ~a_i;
      end
   end

   assign press_o = a_i & ~a_prev_q & armed_q;

endmodule

// File: rtl/memory_turn_ctrl.sv
// Two-card turn sequencer: reads both picks from the board, compares them,
// keeps matched pairs face-up, hides mismatches after SHOW_CYCLES clocks.
module memory_turn_ctrl #(
   parameter int NUM_CARDS   = 36,
   parameter int VAL_W       = 5,
   parameter int SHOW_CYCLES = 25_000_000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 A,
   input  logic [5:0]           mem6x6,
   output logic [5:0]           board_addr,
   input  logic [VAL_W-1:0]     board_data,
   output logic [VAL_W-1:0]     data1,
   output logic [VAL_W-1:0]     data2,
   output logic [NUM_CARDS-1:0] revealed,
   output logic [NUM_CARDS-1:0] matched,
   output logic [4:0]           pairsFound,
   output logic [2:0]           inputState,
   output logic                 match,
   output logic                 turn_done,
   output logic                 GO
);

   import mem_game_pkg::*;

   localparam int HALF    = NUM_CARDS / 2;
   localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

   state_e               state_q, state_d;
   logic [POS_W-1:0]     pos1_q, pos1_d;
   logic [POS_W-1:0]     pos2_q, pos2_d;
   logic [POS_W-1:0]     addr_q, addr_d;
   logic [VAL_W-1:0]     data1_q, data1_d;
   logic [VAL_W-1:0]     data2_q, data2_d;
   logic [NUM_CARDS-1:0] revealed_q, revealed_d;
   logic [NUM_CARDS-1:0] matched_q, matched_d;
   logic [4:0]           pairs_q, pairs_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 match_q, match_d;
   logic                 turn_done_q, turn_done_d;
   logic                 go_q, go_d;

   logic press;
   logic cursor_matched;
   logic pick_ok;

   press_edge u_press_edge (
      .clock_i (clock),
      .reset_i (reset),
      .a_i     (A),
      .press_o (press)
   );

   // Looping over the board avoids indexing past NUM_CARDS when the cursor is off-board.
   always_comb begin
      cursor_matched = 1'b0;
      for (int i = 0; i < NUM_CARDS; i++) begin
         if (i == int'(mem6x6)) cursor_matched = matched_q[i];
      end
      pick_ok = press && (int'(mem6x6) < NUM_CARDS) && !cursor_matched;
   end

   // NOTE: every _d gets its hold value before the case, so no path leaves a latch.
   always_comb begin
      state_d     = state_q;
      pos1_d      = pos1_q;
      pos2_d      = pos2_q;
      addr_d      = addr_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      revealed_d  = revealed_q;
      matched_d   = matched_q;
      pairs_d     = pairs_q;
      timer_d     = timer_q;
      match_d     = 1'b0;
      turn_done_d = 1'b0;
      go_d        = go_q;

      unique case (state_q)
         PICK1: begin
            if (pick_ok) begin
               pos1_d  = mem6x6;
               addr_d  = mem6x6;
               state_d = READ1;
            end
         end
         READ1: begin
            data1_d = board_data;
            for (int i = 0; i < NUM_CARDS; i++) begin
               if (i == int'(pos1_q)) revealed_d[i] = 1'b1;
            end
            state_d = PICK2;
         end
         PICK2: begin
            if (pick_ok && (mem6x6 != pos1_q)) begin
               pos2_d  = mem6x6;
               addr_d  = mem6x6;
               state_d = READ2;
            end
         end
         READ2: begin
            data2_d = board_data;
            for (int i = 0; i < NUM_CARDS; i++) begin
               if (i == int'(pos2_q)) revealed_d[i] = 1'b1;
            end
            state_d = COMPARE;
         end
         COMPARE: begin
            if (data1_q == data2_q) begin
               for (int i = 0; i < NUM_CARDS; i++) begin
                  if (i == int'(pos1_q) || i == int'(pos2_q)) matched_d[i] = 1'b1;
               end
               pairs_d     = pairs_q + 5'd1;
               match_d     = 1'b1;
               turn_done_d = 1'b1;
               if (pairs_d == 5'(HALF)) begin
                  go_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = PICK1;
               end
            end else begin
               timer_d = TIMER_W'(SHOW_CYCLES - 1);
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (timer_q == '0) begin
               for (int i = 0; i < NUM_CARDS; i++) begin
                  if (i == int'(pos1_q) || i == int'(pos2_q)) revealed_d[i] = 1'b0;
               end
               turn_done_d = 1'b1;
               state_d     = PICK1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         DONE: begin
            go_d = 1'b1;
         end
         default: state_d = PICK1;
      endcase
   end

   // NOTE: state registers use <= so every flop samples pre-edge values together.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= PICK1;
         pos1_q      <= '0;
         pos2_q      <= '0;
         addr_q      <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         revealed_q  <= '0;
         matched_q   <= '0;
         pairs_q     <= '0;
         timer_q     <= '0;
         match_q     <= 1'b0;
         turn_done_q <= 1'b0;
         go_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos1_q      <= pos1_d;
         pos2_q      <= pos2_d;
         addr_q      <= addr_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         revealed_q  <= revealed_d;
         matched_q   <= matched_d;
         pairs_q     <= pairs_d;
         timer_q     <= timer_d;
         match_q     <= match_d;
         turn_done_q <= turn_done_d;
         go_q        <= go_d;
      end
   end

   assign board_addr = addr_q;
   assign data1      = data1_q;
   assign data2      = data2_q;
   assign revealed   = revealed_q;
   assign matched    = matched_q;
   assign pairsFound = pairs_q;
   assign inputState = state_q;
   assign match      = match_q;
   assign turn_done  = turn_done_q;
   assign GO         = go_q;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Directed bench for memory_turn_ctrl with a value(i) = i mod 18 board and SHOW_CYCLES = 4.
module tb_memory_turn_ctrl;

   localparam int NC = 36;
   localparam int VW = 5;

   localparam logic [2:0] S_PICK1   = 3'd0;
   localparam logic [2:0] S_PICK2   = 3'd2;
   localparam logic [2:0] S_COMPARE = 3'd4;
   localparam logic [2:0] S_SHOW    = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic          clock = 1'b0;
   logic          reset;
   logic          A;
   logic [5:0]    mem6x6;
   logic [5:0]    board_addr;
   logic [VW-1:0] board_data;
   logic [VW-1:0] data1, data2;
   logic [NC-1:0] revealed, matched;
   logic [4:0]    pairsFound;
   logic [2:0]    inputState;
   logic          match, turn_done, GO;

   int n_vec  = 0;
   int n_miss = 0;

   memory_turn_ctrl #(.NUM_CARDS(NC), .VAL_W(VW), .SHOW_CYCLES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .A          (A),
      .mem6x6     (mem6x6),
      .board_addr (board_addr),
      .board_data (board_data),
      .data1      (data1),
      .data2      (data2),
      .revealed   (revealed),
      .matched    (matched),
      .pairsFound (pairsFound),
      .inputState (inputState),
      .match      (match),
      .turn_done  (turn_done),
      .GO         (GO)
   );

   always #5 clock = ~clock;

   assign board_data = VW'(board_addr % 6'd18);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input int pos);
      mem6x6 = 6'(pos);
      A = 1'b1;
      tick();
      A = 1'b0;
      tick();
   endtask

   logic [63:0] base;
   int exp_pairs;

   initial begin
      reset = 1'b1;
      A = 1'b0;
      mem6x6 = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_state", 64'(inputState), 64'(S_PICK1));
      check("rst_revealed", 64'(revealed), 64'd0);
      check("rst_matched", 64'(matched), 64'd0);
      check("rst_pairs", 64'(pairsFound), 64'd0);
      check("rst_go", 64'(GO), 64'd0);

      // matching pair 0 / 18
      press(0);
      check("m_state_pick2", 64'(inputState), 64'(S_PICK2));
      check("m_revealed1", 64'(revealed), 64'd1);
      press(18);
      check("m_state_cmp", 64'(inputState), 64'(S_COMPARE));
      check("m_data1", 64'(data1), 64'd0);
      check("m_data2", 64'(data2), 64'd0);
      base = (64'd1 << 0) | (64'd1 << 18);
      check("m_revealed2", 64'(revealed), base);
      tick();
      check("m_match", 64'(match), 64'd1);
      check("m_turn_done", 64'(turn_done), 64'd1);
      check("m_matched", 64'(matched), base);
      check("m_pairs", 64'(pairsFound), 64'd1);
      check("m_state", 64'(inputState), 64'(S_PICK1));
      tick();
      check("m_match_pulse", 64'(match), 64'd0);

      // mismatch 3 / 4 with button activity during SHOW
      press(3);
      check("x_addr", 64'(board_addr), 64'd3);
      check("x_data1", 64'(data1), 64'd3);
      press(4);
      check("x_data2", 64'(data2), 64'd4);
      tick();
      check("x_show1", 64'(inputState), 64'(S_SHOW));
      mem6x6 = 6'd10;
      A = 1'b1;
      tick();
      check("x_show2", 64'(inputState), 64'(S_SHOW));
      A = 1'b0;
      tick();
      check("x_show3", 64'(inputState), 64'(S_SHOW));
      A = 1'b1;
      tick();
      check("x_show4", 64'(inputState), 64'(S_SHOW));
      check("x_rev_shown", 64'(revealed), base | (64'd1 << 3) | (64'd1 << 4));
      tick();
      check("x_back_pick1", 64'(inputState), 64'(S_PICK1));
      check("x_turn_done", 64'(turn_done), 64'd1);
      check("x_match_low", 64'(match), 64'd0);
      check("x_rev_hidden", 64'(revealed), base);
      check("x_matched", 64'(matched), base);
      A = 1'b0;
      tick();
      check("x_no_extra_turn", 64'(inputState), 64'(S_PICK1));
      check("x_turn_done_low", 64'(turn_done), 64'd0);

      // illegal picks
      press(40);
      check("i_off_board", 64'(inputState), 64'(S_PICK1));
      press(0);
      check("i_matched_p1", 64'(inputState), 64'(S_PICK1));
      press(5);
      check("i_first5", 64'(inputState), 64'(S_PICK2));
      press(5);
      check("i_same_pos", 64'(inputState), 64'(S_PICK2));
      press(40);
      check("i_off_board2", 64'(inputState), 64'(S_PICK2));
      press(18);
      check("i_matched_p2", 64'(inputState), 64'(S_PICK2));
      press(23);
      check("i_data2", 64'(data2), 64'd5);
      tick();
      check("i_match", 64'(match), 64'd1);
      check("i_pairs", 64'(pairsFound), 64'd2);

      // reset mid-SHOW with A held high
      press(3);
      press(4);
      tick();
      tick();
      check("r_in_show", 64'(inputState), 64'(S_SHOW));
      mem6x6 = 6'd6;
      A = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("r_state", 64'(inputState), 64'(S_PICK1));
      check("r_revealed", 64'(revealed), 64'd0);
      check("r_matched", 64'(matched), 64'd0);
      check("r_pairs", 64'(pairsFound), 64'd0);
      check("r_addr", 64'(board_addr), 64'd0);
      check("r_data", 64'({data1, data2}), 64'd0);
      check("r_pulses", 64'({match, turn_done, GO}), 64'd0);
      tick();
      check("r_held_a1", 64'(inputState), 64'(S_PICK1));
      tick();
      check("r_held_a2", 64'(inputState), 64'(S_PICK1));
      A = 1'b0;
      tick();
      press(6);
      check("r_rearmed", 64'(inputState), 64'(S_PICK2));
      check("r_data1", 64'(data1), 64'd6);
      press(24);
      tick();
      check("r_pairs1", 64'(pairsFound), 64'd1);

      // full game
      exp_pairs = 1;
      for (int k = 0; k < 18; k++) begin
         if (k != 6) begin
            press(k);
            press(k + 18);
            tick();
            exp_pairs++;
            check("g_pairs", 64'(pairsFound), 64'(exp_pairs));
            check("g_go", 64'(GO), (exp_pairs == 18) ? 64'd1 : 64'd0);
            check("g_state", 64'(inputState), (exp_pairs == 18) ? 64'(S_DONE) : 64'(S_PICK1));
         end
      end
      check("g_all_matched", 64'(matched), 64'hF_FFFF_FFFF);
      press(2);
      press(20);
      press(40);
      tick();
      check("d_state", 64'(inputState), 64'(S_DONE));
      check("d_pairs", 64'(pairsFound), 64'd18);
      check("d_go", 64'(GO), 64'd1);
      check("d_data1", 64'(data1), 64'd17);
      check("d_match", 64'(match), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
